reg_bus_spi_initiator: RTL



---
 rtl/reg_bus_spi_initiator.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_spi_initiator.sv
// Mode-0 SPI byte receiver feeding a small FIFO that replays {addr[2:0],data[4:0]} writes on a strobed register bus.
// Optional macro SPI_MISO_ECHO_EN adds a miso port that echoes the last completed byte during the next frame.
module reg_bus_spi_initiator #(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       overflow_clr,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
`ifdef SPI_MISO_ECHO_EN
  ,
  output logic       miso
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // input synchronizers, MSB is the oldest (synchronized) stage
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // deserializer: only the previous 7 bits are kept, the 8th arrives with the push
  logic [6:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       push_req;
  logic [7:0] push_word;

  always_comb begin
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    push_req  = 1'b0;
    push_word = {shift_q, mosi_s};
    if (cs_s) begin
      bitcnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d  = {shift_q[5:0], mosi_s};
      bitcnt_d = bitcnt_q + 3'd1;
      push_req = (bitcnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop, push_ok, drop;
  state_t        state_q, state_d;

  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign push_ok = push_req && ((count_q != CW'(FIFO_DEPTH)) || pop);
  assign drop    = push_req && !push_ok;
  assign count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // issue FSM; one down-counter serves both the strobe and the gap phase
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    addr_q, addr_d;
  logic [4:0]    data_q, data_d;
  logic          strobe_q, busy_q, full_q, ovf_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          addr_d  = mem_q[rd_ptr_q][7:5];
          data_d  = mem_q[rd_ptr_q][4:0];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        tmr_d   = TW'(STROBE_CYCLES - 1);
      end
      STROBE: begin
        if (tmr_q == '0) begin
          state_d = HOLD;
          tmr_d   = TW'(GAP_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      HOLD: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= (state_d == STROBE);
      busy_q   <= (count_d != '0) || (state_d != IDLE);
      full_q   <= (count_d == CW'(FIFO_DEPTH));
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign write_strobe = strobe_q;
  assign address      = addr_q;
  assign data         = data_q;
  assign busy         = busy_q;
  assign fifo_full    = full_q;
  assign overflow     = ovf_q;

`ifdef SPI_MISO_ECHO_EN
  // echo path: load on frame start, shift on sclk falling so the host samples on rising
  logic       cs_prev_q;
  logic [7:0] last_q, tx_q;
  logic       sclk_fall, cs_fall;

  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_q <= 1'b1;
      last_q    <= 8'h00;
      tx_q      <= 8'h00;
    end else begin
      cs_prev_q <= cs_s;
      if (push_req) last_q <= push_word;
      if (cs_fall)                  tx_q <= last_q;
      else if (sclk_fall && !cs_s)  tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  assign miso = cs_s ? 1'b0 : tx_q[7];
`endif

endmodule
